// File: rtl/sw_debounce4.sv
// rtl/sw_debounce4.sv - four-channel switch synchronizer and debouncer with edge strobes
module sw_debounce4 #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_in,
   output logic [3:0] sw_out,
   output logic [3:0] sw_rise,
   output logic [3:0] sw_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [3:0]       s1;
   logic [3:0]       s2;
   logic [CNT_W-1:0] cnt      [4];
   logic [CNT_W-1:0] cnt_next [4];
   logic [3:0]       flip;

   // A flip happens only once s2 has disagreed with the output for a full window.
   always_comb begin
      flip = '0;
      for (int i = 0; i < 4; i++) begin
         cnt_next[i] = '0;
         if (s2[i] != sw_out[i]) begin
            if (cnt[i] == CNT_LAST) begin
               flip[i] = 1'b1;
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         sw_out  <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1      <= sw_in;
         s2      <= s1;
         sw_out  <= sw_out ^ flip;
         sw_rise <= flip & s2;
         sw_fall <= flip & ~s2;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

endmodule

// File: tb/tb_sw_debounce4.sv
// tb/tb_sw_debounce4.sv - directed self-checking bench for sw_debounce4
module tb_sw_debounce4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_in;
   logic [3:0] sw_out;
   logic [3:0] sw_rise;
   logic [3:0] sw_fall;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   sw_debounce4 #(.STABLE_CYCLES(4), .CNT_W(20)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (sw_in),
      .sw_out  (sw_out),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      total++;
      assert (observed === expected) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Apply one input vector, let one rising edge pass, then check all outputs.
   task automatic cyc(input string tag, input logic [3:0] in_v,
                      input logic [3:0] e_out, input logic [3:0] e_rise, input logic [3:0] e_fall);
      sw_in = in_v;
      @(posedge clk);
      #1;
      check({tag, ".out"},  sw_out,  e_out);
      check({tag, ".rise"}, sw_rise, e_rise);
      check({tag, ".fall"}, sw_fall, e_fall);
   endtask

   initial begin
      rst   = 1'b1;
      sw_in = 4'b1111;

      // reset held with all inputs high
      repeat (3) cyc("reset_hold", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;
      repeat (5) cyc("release_wait", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      cyc("release_rise", 4'b1111, 4'b1111, 4'b1111, 4'b0000);
      cyc("release_after", 4'b1111, 4'b1111, 4'b0000, 4'b0000);

      // all channels fall together
      repeat (5) cyc("all_fall_wait", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
      cyc("all_fall", 4'b0000, 4'b0000, 4'b0000, 4'b1111);
      cyc("all_fall_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // clean change on channel 0
      repeat (5) cyc("clean_rise_wait", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      cyc("clean_rise", 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      cyc("clean_rise_after", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      repeat (5) cyc("clean_fall_wait", 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      cyc("clean_fall", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      cyc("clean_fall_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // bounce on channel 1: 1,0,1,0 then held 1 from the fifth vector
      cyc("bounce0", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      cyc("bounce1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      cyc("bounce2", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      cyc("bounce3", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      repeat (5) cyc("bounce_hold", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      cyc("bounce_rise", 4'b0010, 4'b0010, 4'b0010, 4'b0000);
      repeat (3) cyc("bounce_after", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
      repeat (5) cyc("bounce_ret_wait", 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      cyc("bounce_ret_fall", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
      cyc("bounce_ret_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // three-sample glitch on channel 2 must be swallowed
      repeat (3) cyc("glitch_high", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      repeat (8) cyc("glitch_low", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // a following full-length pulse still needs the whole window
      repeat (5) cyc("glitch_full_wait", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      cyc("glitch_full_rise", 4'b0100, 4'b0100, 4'b0100, 4'b0000);
      repeat (5) cyc("glitch_full_ret", 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      cyc("glitch_full_fall", 4'b0000, 4'b0000, 4'b0000, 4'b0100);

      // simultaneous rise on channels 1 and 3
      repeat (5) cyc("simul_wait", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
      cyc("simul_rise", 4'b1010, 4'b1010, 4'b1010, 4'b0000);
      cyc("simul_after", 4'b1010, 4'b1010, 4'b0000, 4'b0000);
      repeat (5) cyc("simul_fall_wait", 4'b0000, 4'b1010, 4'b0000, 4'b0000);
      cyc("simul_fall", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
      cyc("simul_fall_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // reset two edges into a window on channel 3
      repeat (2) cyc("midrst_window", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b1;
      repeat (2) cyc("midrst_hold", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;
      repeat (5) cyc("midrst_wait", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      cyc("midrst_rise", 4'b1000, 4'b1000, 4'b1000, 4'b0000);
      cyc("midrst_after", 4'b1000, 4'b1000, 4'b0000, 4'b0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sw_debounce4.md
# sw_debounce4

Four-channel input conditioner that sits directly upstream of the lab's and-or-invert gate stage. It synchronizes four raw board switch inputs to the system clock and filters their bounce. It presents clean levels that drive the gate's `a`, `b`, `c` and `d` inputs, plus one-cycle edge strobes for downstream counters and LEDs. Each channel is independent and identical.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronized samples that must differ from the current output before it flips. Legal range is 1 to 2^CNT_W − 1. Board builds override it, e.g. to 1_000_000 for a 10 ms window at 100 MHz.
- `CNT_W`, default 20: width of each per-channel stability counter.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sw_in`  in  4: raw asynchronous switch levels. Bit 0 maps to `a`, bit 1 to `b`, bit 2 to `c`, bit 3 to `d`.
- `sw_out`  out  4: debounced levels, registered.
- `sw_rise`  out  4: one-cycle pulse when the matching `sw_out` bit goes 0→1, registered.
- `sw_fall`  out  4: one-cycle pulse when the matching `sw_out` bit goes 1→0, registered.

## Operation
- Per channel: a 2-flop synchronizer `s1`→`s2`, a counter `cnt[CNT_W-1:0]`, and the output flop `sw_out[i]`.
- Each cycle, with `rst` low:
  - If `s2 == sw_out[i]`: `cnt` ← 0. No output change.
  - If `s2 != sw_out[i]` and `cnt < STABLE_CYCLES-1`: `cnt` ← `cnt+1`.
  - If `s2 != sw_out[i]` and `cnt == STABLE_CYCLES-1`: `sw_out[i]` ← `s2`, `cnt` ← 0. `sw_rise[i]` or `sw_fall[i]` is asserted on the same edge, according to the new value.
- `sw_rise`/`sw_fall` are low in every cycle where no flip occurs, so they are exactly one cycle wide. `sw_rise[i]` and `sw_fall[i]` are never high together.
- Any sample equal to the current output, i.e. a glitch shorter than the window, clears `cnt`. The window restarts from zero.
- `cnt` never exceeds `STABLE_CYCLES-1`, so there is no wrap-around.
- With `STABLE_CYCLES = 1`, the output follows `s2` one edge later; there is no filtering beyond synchronization.
- Channels share nothing. Simultaneous flips on several channels in the same cycle are legal and produce independent strobes.

## Timing
- Reset values after any edge with `rst` high: `s1`, `s2`, `cnt`, `sw_out`, `sw_rise` and `sw_fall` are all 0.
- `rst` has priority over all other activity. Asserting it mid-window discards the partial count, with no strobe.
- When `rst` deasserts while `sw_in[i]` is high, the channel treats that level as a fresh change. `sw_rise[i]` fires after the full latency below.
- Latency: let `sw_in[i]` take a new stable value that is first sampled into `s1` at edge k.
  - `s2` holds the new value after edge k+1.
  - `sw_out[i]` and the matching strobe change at edge k+1+STABLE_CYCLES.
  - With the default `STABLE_CYCLES = 4`, that is edge k+5.
- Minimum accepted pulse width is STABLE_CYCLES+… samples: the input must hold its new value for STABLE_CYCLES consecutive `s2` samples. One fewer sample produces no output change.
- Output changes are spaced at least STABLE_CYCLES cycles apart per channel.
- Outputs are glitch-free and registered, safe to feed combinational logic directly.

## Test plan
All scenarios use `STABLE_CYCLES = 4`.
- Reset: hold `sw_in = 4'b1111`, assert `rst` for 3 cycles → `sw_out = 0`, `sw_rise = 0`, `sw_fall = 0` throughout. Deassert `rst` → `sw_out = 4'b1111` and `sw_rise = 4'b1111` for exactly one cycle, 5 edges after the first sampling edge.
- Clean change: `sw_in[0]` 0→1, held → `sw_out[0]` = 1 at edge k+5 with a single `sw_rise[0]` pulse. Then 1→0 → `sw_fall[0]` pulse 5 edges later.
- Bounce: `sw_in[1]` toggles 1,0,1,0,1 on successive cycles, then holds 1 → no change until 4 consecutive 1 samples reach `s2`. Then exactly one `sw_rise[1]`, with no `sw_fall[1]`.
- Short glitch: `sw_in[2]` high for 3 cycles, then low → `sw_out[2]` stays 0, no strobes, `cnt` returns to 0.
- Simultaneous: `sw_in` 0000→1010 in one cycle → `sw_out = 4'b1010`, with `sw_rise = 4'b1010` for one cycle on the same edge.
- Reset mid-window: change `sw_in[3]`, assert `rst` 2 edges into the window → no strobe. After release, the full 5-edge latency is measured afresh.
